// File: rtl/alu_sweep_checker.sv
// Sweep sequencer and scoreboard: drives every {opcode, A, B} vector into a golden
// and a faulted combinational ALU and accumulates mismatch statistics.
module alu_sweep_checker #(
  parameter bit STOP_ON_FIRST = 1'b0,
  parameter int CNT_W         = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [3:0]       A,
  output logic [3:0]       B,
  output logic [2:0]       opcode,
  input  logic [3:0]       gold_result,
  input  logic             gold_zero,
  input  logic [3:0]       dut_result,
  input  logic             dut_zero,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             first_fail_valid,
  output logic [10:0]      first_fail_vec,
  output logic [7:0]       opcode_fail_mask
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [10:0]      idx;
  logic             mismatch;
  logic             last_vec;
  logic [CNT_W-1:0] count_next;

  // The operands are the vector index itself, so they come straight from a register.
  assign opcode = idx[10:8];
  assign A      = idx[7:4];
  assign B      = idx[3:0];

  assign mismatch   = (dut_result != gold_result) || (dut_zero != gold_zero);
  assign count_next = mismatch_count + CNT_W'(mismatch);
  assign last_vec   = (idx == 11'h7FF) || (STOP_ON_FIRST && mismatch);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_count   <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      opcode_fail_mask <= '0;
    end else if (abort) begin
      // Abort beats start; statistics are left intact for inspection.
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          idx <= '0;
          if (start) begin
            state            <= RUN;
            busy             <= 1'b1;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            opcode_fail_mask <= '0;
          end
        end

        RUN: begin
          if (mismatch) begin
            mismatch_count           <= count_next;
            opcode_fail_mask[opcode] <= 1'b1;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= idx;
            end
          end
          // idx stays on the last scored vector rather than wrapping to 0.
          if (last_vec) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (count_next == '0);
          end else begin
            idx <= idx + 11'd1;
          end
        end

        DONE: begin
          if (start) begin
            state            <= RUN;
            idx              <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            opcode_fail_mask <= '0;
          end
        end

        default: begin
          state <= IDLE;
          idx   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Self-checking bench: behavioural golden/faulted ALUs feed two checker instances
// (full sweep and stop-on-first); expected sweep statistics go through a scoreboard queue.
module tb_alu_sweep_checker;

  typedef struct {
    int         busy_cycles;
    int         count;
    logic       ffv;
    logic [10:0] vec;
    logic [7:0] mask;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  exp_t sb_q[$];

  // Instance 0: full sweep
  logic        start0 = 1'b0, abort0 = 1'b0;
  logic [3:0]  a0, b0, g_res0, d_res0;
  logic [2:0]  op0;
  logic        g_z0, d_z0;
  logic        busy0, done0, pass0, ffv0;
  logic [11:0] cnt0;
  logic [10:0] vec0;
  logic [7:0]  mask0;
  int          fault0 = 0;

  // Instance 1: stop on first mismatch
  logic        start1 = 1'b0, abort1 = 1'b0;
  logic [3:0]  a1, b1, g_res1, d_res1;
  logic [2:0]  op1;
  logic        g_z1, d_z1;
  logic        busy1, done1, pass1, ffv1;
  logic [11:0] cnt1;
  logic [10:0] vec1;
  logic [7:0]  mask1;
  int          fault1 = 0;

  function automatic logic [3:0] alu(logic [2:0] op, logic [3:0] a, logic [3:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  // Fault modes: 0 none, 1 opcode[1] stuck-at-1, 2 zero flag inverted at 11'h5A3
  function automatic logic [4:0] faulty_alu(int mode, logic [10:0] v);
    logic [3:0] r;
    logic       z;
    if (mode == 1) r = alu(v[10:8] | 3'b010, v[7:4], v[3:0]);
    else           r = alu(v[10:8], v[7:4], v[3:0]);
    z = (r == 4'd0);
    if (mode == 2 && v == 11'h5A3) z = ~z;
    return {r, z};
  endfunction

  always_comb begin
    g_res0 = alu(op0, a0, b0);
    g_z0   = (g_res0 == 4'd0);
    {d_res0, d_z0} = faulty_alu(fault0, {op0, a0, b0});
    g_res1 = alu(op1, a1, b1);
    g_z1   = (g_res1 == 4'd0);
    {d_res1, d_z1} = faulty_alu(fault1, {op1, a1, b1});
  end

  alu_sweep_checker #(.STOP_ON_FIRST(1'b0), .CNT_W(12)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .A(a0), .B(b0), .opcode(op0),
    .gold_result(g_res0), .gold_zero(g_z0), .dut_result(d_res0), .dut_zero(d_z0),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch_count(cnt0),
    .first_fail_valid(ffv0), .first_fail_vec(vec0), .opcode_fail_mask(mask0)
  );

  alu_sweep_checker #(.STOP_ON_FIRST(1'b1), .CNT_W(12)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .A(a1), .B(b1), .opcode(op1),
    .gold_result(g_res1), .gold_zero(g_z1), .dut_result(d_res1), .dut_zero(d_z1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_count(cnt1),
    .first_fail_valid(ffv1), .first_fail_vec(vec1), .opcode_fail_mask(mask1)
  );

  // Reference statistics after scoring at most 'limit' vectors from index 0.
  function automatic exp_t model(int mode, bit stop, int limit);
    exp_t e;
    logic [3:0] g;
    logic [4:0] d;
    logic [10:0] v;
    e.busy_cycles = 0; e.count = 0; e.ffv = 1'b0; e.vec = '0; e.mask = '0;
    for (int i = 0; i < limit; i++) begin
      v = 11'(i);
      g = alu(v[10:8], v[7:4], v[3:0]);
      d = faulty_alu(mode, v);
      e.busy_cycles = i + 1;
      if (d != {g, (g == 4'd0)}) begin
        e.count++;
        e.mask[v[10:8]] = 1'b1;
        if (!e.ffv) begin
          e.ffv = 1'b1;
          e.vec = v;
        end
        if (stop) break;
      end
    end
    e.pass = (e.count == 0);
    return e;
  endfunction

  task automatic compare_field(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start on instance 0 and queue the statistics that sweep should produce.
  task automatic applyStimulus(input int mode);
    fault0 = mode;
    sb_q.push_back(model(mode, 1'b0, 2048));
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  // Run instance 0 to done, optionally re-pulsing start mid-sweep, then score it.
  task automatic checkOutput(input string tag, input int pulse_at);
    exp_t e;
    int cycles = 0;
    int guard  = 0;
    int overlap = 0;
    while (!done0 && guard < 5000) begin
      if (busy0) cycles++;
      if (busy0 && done0) overlap++;
      start0 = (cycles == pulse_at);
      guard++;
      @(negedge clk);
    end
    start0 = 1'b0;
    compare_field({tag, "_timeout"}, 32'(guard < 5000), 32'd1);
    if (sb_q.size() == 0) begin
      compare_field({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      compare_field({tag, "_busy_cycles"}, 32'(cycles), 32'(e.busy_cycles));
      compare_field({tag, "_done"}, 32'(done0), 32'd1);
      compare_field({tag, "_busy_low"}, 32'(busy0), 32'd0);
      compare_field({tag, "_pass"}, 32'(pass0), 32'(e.pass));
      compare_field({tag, "_count"}, 32'(cnt0), 32'(e.count));
      compare_field({tag, "_ffv"}, 32'(ffv0), 32'(e.ffv));
      compare_field({tag, "_vec"}, 32'(vec0), 32'(e.vec));
      compare_field({tag, "_mask"}, 32'(mask0), 32'(e.mask));
      compare_field({tag, "_overlap"}, 32'(overlap), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    compare_field({tag, "_busy"}, 32'(busy0), 32'd0);
    compare_field({tag, "_done"}, 32'(done0), 32'd0);
    compare_field({tag, "_pass"}, 32'(pass0), 32'd0);
    compare_field({tag, "_operands"}, 32'({op0, a0, b0}), 32'd0);
    compare_field({tag, "_count"}, 32'(cnt0), 32'd0);
    compare_field({tag, "_ffv"}, 32'(ffv0), 32'd0);
    compare_field({tag, "_vec"}, 32'(vec0), 32'd0);
    compare_field({tag, "_mask"}, 32'(mask0), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int cycles;
    int guard;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");
    compare_field("reset_dut1_busy", 32'(busy1), 32'd0);

    // Clean sweep with golden ALU on both sides
    applyStimulus(0);
    checkOutput("golden", -1);

    // opcode[1] stuck-at-1
    applyStimulus(1);
    checkOutput("stuck_op1", -1);
    compare_field("stuck_op1_mask_const", 32'(mask0), 32'h33);
    compare_field("stuck_op1_vec_const", 32'(vec0), 32'h001);

    // Same fault with stop-on-first
    fault1 = 1;
    e = model(1, 1'b1, 2048);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cycles = 0;
    guard  = 0;
    while (!done1 && guard < 100) begin
      if (busy1) cycles++;
      guard++;
      @(negedge clk);
    end
    compare_field("stop_timeout", 32'(guard < 100), 32'd1);
    compare_field("stop_busy_cycles", 32'(cycles), 32'(e.busy_cycles));
    compare_field("stop_busy_cycles_const", 32'(cycles), 32'd2);
    compare_field("stop_count", 32'(cnt1), 32'd1);
    compare_field("stop_vec", 32'(vec1), 32'h001);
    compare_field("stop_mask", 32'(mask1), 32'(e.mask));
    compare_field("stop_pass", 32'(pass1), 32'd0);

    // Single zero-flag fault at 11'h5A3
    applyStimulus(2);
    checkOutput("zero_5a3", -1);
    compare_field("zero_5a3_mask_const", 32'(mask0), 32'h20);

    // Abort after 100 busy cycles: vectors 0..98 scored
    fault0 = 1;
    e = model(1, 1'b0, 99);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (99) @(negedge clk);
    compare_field("abort_pre_busy", 32'(busy0), 32'd1);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    compare_field("abort_busy", 32'(busy0), 32'd0);
    compare_field("abort_done", 32'(done0), 32'd0);
    compare_field("abort_operands", 32'({op0, a0, b0}), 32'd0);
    compare_field("abort_count_hold", 32'(cnt0), 32'(e.count));
    compare_field("abort_mask_hold", 32'(mask0), 32'(e.mask));
    compare_field("abort_vec_hold", 32'(vec0), 32'(e.vec));
    applyStimulus(0);
    checkOutput("after_abort", -1);

    // Reset mid-sweep
    fault0 = 1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("mid_reset");

    // start pulsed during RUN is ignored
    applyStimulus(0);
    checkOutput("start_in_run", 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/alu_sweep_checker.md
# alu_sweep_checker

Sequencer and scoreboard for mutation testing of the 4-bit ALU family. It drives every (opcode, A, B) combination into a golden ALU and a faulted ALU in parallel, compares their result and zero flag each cycle, and accumulates pass/fail statistics: mismatch count, first failing vector, and a per-opcode failure mask. Both ALUs sit outside this block and are purely combinational.

## Interface
- STOP_ON_FIRST, default 0: 1 ends the sweep on the first mismatch; 0 sweeps all 2048 vectors.
- CNT_W, default 12: width of mismatch_count. Must be ≥12 so a full-sweep count cannot overflow.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sweep from IDLE or DONE.
- abort  in  1  ends a sweep in progress and returns to IDLE.
- A  out  4  operand A to both ALUs (registered).
- B  out  4  operand B to both ALUs (registered).
- opcode  out  3  opcode to both ALUs (registered).
- gold_result  in  4  golden ALU result.
- gold_zero  in  1  golden ALU zero flag.
- dut_result  in  4  faulted ALU result.
- dut_zero  in  1  faulted ALU zero flag.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.
- pass  out  1  valid only with done; 1 means mismatch_count == 0.
- mismatch_count  out  CNT_W  number of failing vectors in this sweep.
- first_fail_valid  out  1  first_fail_vec holds a captured value.
- first_fail_vec  out  11  {opcode, A, B} of the first failing vector.
- opcode_fail_mask  out  8  bit k is set once any vector with opcode k fails.

## Operation
- The vector index is idx[10:0] = {opcode, A, B}. B changes fastest. The sweep runs from 0 to 2047.
- A vector mismatches when (dut_result != gold_result) or (dut_zero != gold_zero). The comparison is made on the current vector's combinational response.
- The FSM has three states: IDLE, RUN, DONE.
- IDLE: idx = 0. On start, clear mismatch_count, first_fail_valid, first_fail_vec and opcode_fail_mask, then go to RUN.
- RUN, on each cycle:
  - If the current vector mismatches: increment mismatch_count and set opcode_fail_mask[opcode].
  - If the current vector mismatches and first_fail_valid is 0: capture idx into first_fail_vec and set first_fail_valid.
  - Then advance idx by 1.
- RUN exits to DONE when idx == 2047 is evaluated, or when STOP_ON_FIRST = 1 and a mismatch is seen. On exit, idx holds its value and does not wrap.
- DONE: all statistics hold. start clears them and begins a new sweep in RUN at idx 0.
- start while in RUN is ignored.
- abort in RUN or DONE returns to IDLE with idx = 0. Statistics hold their values, done = 0.
- If abort and start are both high, abort wins.
- Reset (synchronous, any state, including mid-sweep) sets:
  - state to IDLE;
  - A, B, opcode, busy, done, pass, first_fail_valid to 0;
  - mismatch_count, first_fail_vec, opcode_fail_mask to 0.
- pass = done & (mismatch_count == 0).

## Timing
- Operands are registered, so a new vector is presented on the edge after it is selected. The comparison and accumulation for that vector happen on the next edge.
- start high at edge N: busy = 1 and vector 0 driven after edge N. Vector 0 is scored at edge N+1.
- Full sweep: vector 2047 is scored at edge N+2048, and done rises after that same edge. busy is high for exactly 2048 cycles.
- STOP_ON_FIRST with the first mismatch at index k: the failing vector is scored at edge N+k+1, and done rises after it.
- busy and done are never high at the same time.
- The block has no combinational path from any input to any output.

## Test plan
- Golden ALU wired to both inputs, start pulse → after exactly 2048 busy cycles:
  - done = 1, pass = 1;
  - mismatch_count = 0, first_fail_valid = 0, opcode_fail_mask = 8'h00.
- DUT with opcode[1] stuck-at-1 → pass = 0, mismatch_count > 0, first_fail_vec = 11'h001 (ADD vs AND at A = 0, B = 1), opcode_fail_mask = 8'h33.
- Same DUT with STOP_ON_FIRST = 1 → done after 2 busy cycles, mismatch_count = 1, first_fail_vec = 11'h001.
- Golden DUT except dut_zero inverted only at idx 11'h5A3 → mismatch_count = 1, first_fail_vec = 11'h5A3, opcode_fail_mask = 8'h20.
- abort at busy cycle 100 → IDLE next cycle, busy = 0, done = 0, opcode = A = B = 0. A following start clears the statistics and completes a clean 2048-cycle sweep.
- rst asserted mid-RUN, and separately start pulsed during RUN → reset returns all outputs to 0. The start pulse in RUN has no effect: sweep length is still 2048.
